mips_cpu_reg_file_mp: RTL and testbench
=======================================

// Module: mips_cpu_reg_file_mp
// PURPOSE
//  Parametrised multi-read-port GPR file for the MIPS core: 2^ADDR_W x DATA_W.
//  Adds write-through bypass and a per-register pending scoreboard for multi-cycle producers (loads, mult/div).
//  Sits between decode (read/lock) and writeback (write); busy outputs drive the hazard/stall unit.
// PARAMETERS
//  DATA_W   32  register width in bits
//  ADDR_W   5   register address width; NREGS = 2**ADDR_W
//  NUM_RD   2   number of independent read ports (1..4)
//  BYPASS   1   1: same-cycle write forwarded to reads; 0: reads see only registered state
// PORTS
//  clk          in   1               rising-edge clock
//  reset        in   1               asynchronous, active-low reset
//  rd_addr      in   NUM_RD*ADDR_W   read addresses; port i = bits [i*ADDR_W +: ADDR_W]
//  rd_data      out  NUM_RD*DATA_W   read data; port i = bits [i*DATA_W +: DATA_W]
//  rd_busy      out  NUM_RD          1 = register on port i has an outstanding producer
//  wr_en        in   1               writeback strobe
//  wr_addr      in   ADDR_W          writeback destination
//  wr_data      in   DATA_W          writeback value
//  lock_en      in   1               issue strobe: mark lock_addr pending
//  lock_addr    in   ADDR_W          register claimed by a multi-cycle producer
//  pending_cnt  out  ADDR_W+1        number of registers currently pending
//  register_v0  out  DATA_W          debug copy of reg 2 ($v0), registered state only
// BEHAVIOUR
//  Reset (reset=0, async): all registers = 0, all pending bits = 0, pending_cnt = 0.
//   rd_data/rd_busy then reflect cleared state; reset mid-lock discards every pending claim.
//  Register 0: always reads 0, never pending; writes and locks to addr 0 are ignored.
//  Write: on posedge clk with wr_en=1 and wr_addr!=0, regs[wr_addr] <= wr_data.
//  Read: combinational, zero-cycle latency, all ports independent; duplicate addresses allowed.
//   BYPASS=1: if wr_en && wr_addr==rd_addr_i && rd_addr_i!=0 then rd_data_i = wr_data.
//   BYPASS=0: rd_data_i = regs[rd_addr_i]; new value visible the cycle after the write edge.
//  Scoreboard (pending[NREGS-1:1]), updated on posedge clk:
//   wr_en && wr_addr!=0   -> pending[wr_addr] <= 0
//   lock_en && lock_addr!=0 -> pending[lock_addr] <= 1
//   same addr locked and written in one cycle -> lock wins (new producer), pending stays 1.
//   lock of an already-pending reg: no change (stays 1, count unchanged).
//   write to a non-pending reg: normal write, no scoreboard change.
//  rd_busy_i = pending[rd_addr_i] && !(BYPASS && wr_en && wr_addr==rd_addr_i); 0 for addr 0.
//   BYPASS=0: rd_busy_i = pending[rd_addr_i] (no release until after the write edge).
//  pending_cnt: registered popcount of pending, updated in the same edge as pending
//   (+1 set-only, -1 clear-only, 0 both/neither); range 0..NREGS-1, never wraps.
//  register_v0 = regs[2], registered; bypass not applied.
//  Width rules: no arithmetic on data; addresses compared at full ADDR_W.
//  Undriven/X addresses are out of contract; all in-range addresses are legal.
// TESTING
//  1 Reset: pulse reset low mid-cycle, no clk -> all rd_data=0, rd_busy=0, pending_cnt=0 immediately.
//  2 Write/read: write 0xDEADBEEF to r5, read r5 on both ports next cycle -> 0xDEADBEEF;
//    write r0=0x1234 -> r0 reads 0.
//  3 Bypass: BYPASS=1, wr_en r7=0xA5A5A5A5 with rd_addr0=7 same cycle -> rd_data0=0xA5A5A5A5;
//    BYPASS=0 -> old value, new value next cycle.
//  4 Scoreboard: lock r8 -> next cycle rd_busy=1 on r8, pending_cnt=1;
//    write r8=0x55 -> busy drops combinationally (BYPASS=1), pending_cnt=0 after edge.
//  5 Collision: lock r9 and write r9=0x11 same cycle -> r9=0x11 stored, still pending, cnt unchanged+1;
//    lock r0 -> no effect.
//  6 Reset mid-op: lock r3,r4, assert reset -> pending_cnt=0, rd_busy=0, r3/r4 read 0 after release.

Source files
------------

// File: rtl/mips_cpu_reg_file_mp_if.sv
// Register-file bus: read ports, writeback, scoreboard lock and debug taps.
// master = decode/writeback side (drives addresses/data), slave = register file.
interface mips_cpu_reg_file_mp_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NUM_RD = 2
);
   logic [NUM_RD*ADDR_W-1:0] rd_addr;
   logic [NUM_RD*DATA_W-1:0] rd_data;
   logic [NUM_RD-1:0]        rd_busy;
   logic                     wr_en;
   logic [ADDR_W-1:0]        wr_addr;
   logic [DATA_W-1:0]        wr_data;
   logic                     lock_en;
   logic [ADDR_W-1:0]        lock_addr;
   logic [ADDR_W:0]          pending_cnt;
   logic [DATA_W-1:0]        register_v0;

   modport master (
      output rd_addr, wr_en, wr_addr, wr_data,
      output lock_en, lock_addr,
      input  rd_data, rd_busy, pending_cnt, register_v0
   );

   modport slave (
      input  rd_addr, wr_en, wr_addr, wr_data,
      input  lock_en, lock_addr,
      output rd_data, rd_busy, pending_cnt, register_v0
   );
endinterface

// File: rtl/mips_cpu_reg_file_mp.sv
// Multi-read-port GPR file with write-through bypass and pending scoreboard.
// Ports: clk, reset (async, active-low), bus (slave: reads, write, lock, debug).
module mips_cpu_reg_file_mp #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NUM_RD = 2,
   parameter int BYPASS = 1
) (
   input logic                   clk,
   input logic                   reset,
   mips_cpu_reg_file_mp_if.slave bus
);
   localparam int NREGS  = 2**ADDR_W;
   localparam bit BYP_EN = (BYPASS != 0);

   logic [DATA_W-1:0] regs_q [NREGS];
   logic [DATA_W-1:0] regs_d [NREGS];
   logic [NREGS-1:0]  pending_q, pending_d;
   logic [ADDR_W:0]   cnt_q, cnt_d;
   logic              wr_hit, lock_hit;
   logic              cnt_inc, cnt_dec;

   // r0 is never written or locked, so regs_q[0]/pending_q[0]
   // stay at their reset value of 0 and reads need no special case.
   always_comb begin
      wr_hit   = bus.wr_en && (bus.wr_addr != '0);
      lock_hit = bus.lock_en && (bus.lock_addr != '0);
      cnt_inc  = lock_hit && !pending_q[bus.lock_addr];
      // a lock on the same register re-claims it, so no release
      cnt_dec  = wr_hit && pending_q[bus.wr_addr]
               && !(lock_hit && (bus.lock_addr == bus.wr_addr));
      regs_d    = regs_q;
      pending_d = pending_q;
      if (wr_hit) begin
         regs_d[bus.wr_addr]    = bus.wr_data;
         pending_d[bus.wr_addr] = 1'b0;
      end
      if (lock_hit) begin
         pending_d[bus.lock_addr] = 1'b1;
      end
      cnt_d = cnt_q + {{ADDR_W{1'b0}}, cnt_inc}
                    - {{ADDR_W{1'b0}}, cnt_dec};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
         pending_q <= '0;
         cnt_q     <= '0;
      end else begin
         regs_q    <= regs_d;
         pending_q <= pending_d;
         cnt_q     <= cnt_d;
      end
   end

   logic [NUM_RD*DATA_W-1:0] rd_data_c;
   logic [NUM_RD-1:0]        rd_busy_c;
   logic [ADDR_W-1:0]        ra;
   logic                     fwd;

   // wr_hit already excludes r0, so forwarding never touches r0
   always_comb begin
      rd_data_c = '0;
      rd_busy_c = '0;
      ra        = '0;
      fwd       = 1'b0;
      for (int i = 0; i < NUM_RD; i++) begin
         ra  = bus.rd_addr[i*ADDR_W +: ADDR_W];
         fwd = BYP_EN && wr_hit && (bus.wr_addr == ra);
         rd_data_c[i*DATA_W +: DATA_W] = fwd ? bus.wr_data
                                             : regs_q[ra];
         rd_busy_c[i] = pending_q[ra] && !fwd;
      end
   end

   assign bus.rd_data     = rd_data_c;
   assign bus.rd_busy     = rd_busy_c;
   assign bus.pending_cnt = cnt_q;
   assign bus.register_v0 = regs_q[2];
endmodule

// File: tb/tb_mips_cpu_reg_file_mp.sv
// Directed bench for mips_cpu_reg_file_mp: BYPASS=1 and BYPASS=0 copies
// driven with identical stimulus, checked against hand-computed values.
module tb_mips_cpu_reg_file_mp;
   logic clk;
   logic reset;
   int   total;
   int   passed;

   mips_cpu_reg_file_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) bus1 ();
   mips_cpu_reg_file_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) bus0 ();

   mips_cpu_reg_file_mp #(
      .DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(1)
   ) u_byp (
      .clk(clk), .reset(reset), .bus(bus1)
   );

   mips_cpu_reg_file_mp #(
      .DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(0)
   ) u_nobyp (
      .clk(clk), .reset(reset), .bus(bus0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive(input logic [4:0] r0, input logic [4:0] r1,
                        input logic we, input logic [4:0] wa,
                        input logic [31:0] wd,
                        input logic le, input logic [4:0] la);
      bus1.rd_addr = {r1, r0};
      bus0.rd_addr = {r1, r0};
      bus1.wr_en = we;  bus0.wr_en = we;
      bus1.wr_addr = wa; bus0.wr_addr = wa;
      bus1.wr_data = wd; bus0.wr_data = wd;
      bus1.lock_en = le; bus0.lock_en = le;
      bus1.lock_addr = la; bus0.lock_addr = la;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      drive(5'd2, 5'd6, 1'b1, 5'd2, 32'h0000CAFE, 1'b1, 5'd6);
      tick();
      drive(5'd2, 5'd6, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
      total++;
      if (bus1.register_v0 !== 32'h0000CAFE)
         $display("FAIL pre_v0: got %h expected %h",
                  bus1.register_v0, 32'h0000CAFE);
      else passed++;
      total++;
      if (bus1.pending_cnt !== 6'd1)
         $display("FAIL pre_cnt: got %0d expected 1", bus1.pending_cnt);
      else passed++;
      reset = 1'b0;
      #1;
      total++;
      if (bus1.rd_data[31:0] !== 32'h0)
         $display("FAIL rst_data: got %h expected 0", bus1.rd_data[31:0]);
      else passed++;
      total++;
      if (bus1.rd_busy !== 2'b00)
         $display("FAIL rst_busy: got %b expected 00", bus1.rd_busy);
      else passed++;
      total++;
      if (bus1.pending_cnt !== 6'd0)
         $display("FAIL rst_cnt: got %0d expected 0", bus1.pending_cnt);
      else passed++;
      total++;
      if (bus0.register_v0 !== 32'h0)
         $display("FAIL rst_v0: got %h expected 0", bus0.register_v0);
      else passed++;
      #2;
      reset = 1'b1;
      tick();
   endtask

   task automatic test_write_read();
      drive(5'd0, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0);
      tick();
      drive(5'd5, 5'd5, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
      total++;
      if (bus1.rd_data !== {32'hDEADBEEF, 32'hDEADBEEF})
         $display("FAIL wr_rd_r5: got %h expected %h",
                  bus1.rd_data, {32'hDEADBEEF, 32'hDEADBEEF});
      else passed++;
      total++;
      if (bus0.rd_data[63:32] !== 32'hDEADBEEF)
         $display("FAIL wr_rd_r5_nb: got %h expected DEADBEEF",
                  bus0.rd_data[63:32]);
      else passed++;
      drive(5'd0, 5'd5, 1'b1, 5'd0, 32'h00001234, 1'b0, 5'd0);
      total++;
      if (bus1.rd_data[31:0] !== 32'h0)
         $display("FAIL r0_fwd: got %h expected 0", bus1.rd_data[31:0]);
      else passed++;
      tick();
      drive(5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
      total++;
      if (bus1.rd_data !== 64'h0)
         $display("FAIL r0_read: got %h expected 0", bus1.rd_data);
      else passed++;
   endtask

   task automatic test_bypass();
      drive(5'd7, 5'd5, 1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, 5'd0);
      total++;
      if (bus1.rd_data[31:0] !== 32'hA5A5A5A5)
         $display("FAIL byp_fwd: got %h expected A5A5A5A5",
                  bus1.rd_data[31:0]);
      else passed++;
      total++;
      if (bus0.rd_data[31:0] !== 32'h0)
         $display("FAIL nobyp_old: got %h expected 0", bus0.rd_data[31:0]);
      else passed++;
      total++;
      if (bus1.rd_data[63:32] !== 32'hDEADBEEF)
         $display("FAIL byp_other: got %h expected DEADBEEF",
                  bus1.rd_data[63:32]);
      else passed++;
      tick();
      drive(5'd7, 5'd5, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
      total++;
      if (bus0.rd_data[31:0] !== 32'hA5A5A5A5)
         $display("FAIL nobyp_new: got %h expected A5A5A5A5",
                  bus0.rd_data[31:0]);
      else passed++;
   endtask

   task automatic test_scoreboard();
      drive(5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd8);
      tick();
      drive(5'd8, 5'd5, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
      total++;
      if (bus1.rd_busy !== 2'b01)
         $display("FAIL sb_busy: got %b expected 01", bus1.rd_busy);
      else passed++;
      total++;
      if (bus1.pending_cnt !== 6'd1)
         $display("FAIL sb_cnt1: got %0d expected 1", bus1.pending_cnt);
      else passed++;
      drive(5'd8, 5'd5, 1'b1, 5'd8, 32'h00000055, 1'b0, 5'd0);
      total++;
      if (bus1.rd_busy !== 2'b00)
         $display("FAIL sb_release: got %b expected 00", bus1.rd_busy);
      else passed++;
      total++;
      if (bus0.rd_busy !== 2'b01)
         $display("FAIL sb_nb_hold: got %b expected 01", bus0.rd_busy);
      else passed++;
      total++;
      if (bus1.rd_data[31:0] !== 32'h00000055)
         $display("FAIL sb_fwd: got %h expected 55", bus1.rd_data[31:0]);
      else passed++;
      tick();
      drive(5'd8, 5'd5, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
      total++;
      if (bus1.pending_cnt !== 6'd0)
         $display("FAIL sb_cnt0: got %0d expected 0", bus1.pending_cnt);
      else passed++;
      total++;
      if (bus0.rd_busy !== 2'b00)
         $display("FAIL sb_nb_rel: got %b expected 00", bus0.rd_busy);
      else passed++;
   endtask

   task automatic test_collision();
      drive(5'd9, 5'd0, 1'b1, 5'd9, 32'h00000011, 1'b1, 5'd9);
      tick();
      drive(5'd9, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
      total++;
      if (bus1.rd_data[31:0] !== 32'h00000011)
         $display("FAIL col_data: got %h expected 11", bus1.rd_data[31:0]);
      else passed++;
      total++;
      if (bus1.rd_busy !== 2'b01)
         $display("FAIL col_busy: got %b expected 01", bus1.rd_busy);
      else passed++;
      total++;
      if (bus1.pending_cnt !== 6'd1)
         $display("FAIL col_cnt: got %0d expected 1", bus1.pending_cnt);
      else passed++;
      drive(5'd0, 5'd9, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0);
      tick();
      drive(5'd0, 5'd9, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9);
      tick();
      drive(5'd0, 5'd9, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
      total++;
      if (bus1.pending_cnt !== 6'd1)
         $display("FAIL lock_r0_relock: got %0d expected 1",
                  bus1.pending_cnt);
      else passed++;
      total++;
      if (bus1.rd_busy !== 2'b10)
         $display("FAIL r0_busy: got %b expected 10", bus1.rd_busy);
      else passed++;
      drive(5'd9, 5'd10, 1'b1, 5'd9, 32'h00000022, 1'b1, 5'd10);
      tick();
      drive(5'd9, 5'd10, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
      total++;
      if (bus1.pending_cnt !== 6'd1)
         $display("FAIL swap_cnt: got %0d expected 1", bus1.pending_cnt);
      else passed++;
      total++;
      if (bus1.rd_busy !== 2'b10)
         $display("FAIL swap_busy: got %b expected 10", bus1.rd_busy);
      else passed++;
   endtask

   task automatic test_reset_mid();
      drive(5'd0, 5'd0, 1'b1, 5'd4, 32'h00000077, 1'b1, 5'd3);
      tick();
      drive(5'd3, 5'd4, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4);
      tick();
      drive(5'd3, 5'd4, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
      total++;
      if (bus1.pending_cnt !== 6'd3)
         $display("FAIL mid_cnt3: got %0d expected 3", bus1.pending_cnt);
      else passed++;
      total++;
      if (bus1.rd_data[63:32] !== 32'h00000077)
         $display("FAIL mid_r4: got %h expected 77", bus1.rd_data[63:32]);
      else passed++;
      reset = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      total++;
      if (bus1.pending_cnt !== 6'd0)
         $display("FAIL mid_cnt0: got %0d expected 0", bus1.pending_cnt);
      else passed++;
      total++;
      if (bus1.rd_busy !== 2'b00)
         $display("FAIL mid_busy: got %b expected 00", bus1.rd_busy);
      else passed++;
      tick();
      total++;
      if (bus1.rd_data !== 64'h0)
         $display("FAIL mid_data: got %h expected 0", bus1.rd_data);
      else passed++;
   endtask

   initial begin
      total  = 0;
      passed = 0;
      reset  = 1'b0;
      drive(5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
      #12;
      reset = 1'b1;
      tick();
      test_reset();
      test_write_read();
      test_bypass();
      test_scoreboard();
      test_collision();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
